// File: rtl/ext_domain_seq.sv
// Per-domain power sequencer for external subsystems: switch, ack, isolation, reset.
// Optional retention state is built when EXT_DOMAIN_SEQ_RETENTION_EN is defined.
module ext_domain_seq #(
  parameter int NDOMAINS    = 2,
  parameter int ACK_TIMEOUT = 255,
  parameter int RST_DELAY   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NDOMAINS-1:0]   on_req_i,
  input  logic [NDOMAINS-1:0]   switch_ack_i,
  input  logic [NDOMAINS-1:0]   err_clr_i,
  input  logic [NDOMAINS-1:0]   intr_en_i,
  input  logic [NDOMAINS-1:0]   intr_clr_i,
  input  logic [NDOMAINS-1:0]   ret_req_i,
  output logic [NDOMAINS-1:0]   switch_o,
  output logic [NDOMAINS-1:0]   iso_o,
  output logic [NDOMAINS-1:0]   rst_no,
  output logic [NDOMAINS-1:0]   set_retentive_o,
  output logic [NDOMAINS-1:0]   ready_o,
  output logic [NDOMAINS-1:0]   err_o,
  output logic [NDOMAINS-1:0]   intr_pending_o,
  output logic                  intr_o,
  output logic [4*NDOMAINS-1:0] state_dbg_o
);

  localparam int MAX_T = (ACK_TIMEOUT > RST_DELAY) ? ACK_TIMEOUT : RST_DELAY;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam logic [TW-1:0] T_SAT = '1;
  localparam logic [TW-1:0] ACK_T = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] ISO_T = TW'(RST_DELAY - 1);

  localparam logic [3:0] S_OFF     = 4'd0;
  localparam logic [3:0] S_PWR_UP  = 4'd1;
  localparam logic [3:0] S_ISO_OFF = 4'd2;
  localparam logic [3:0] S_RUN     = 4'd3;
  localparam logic [3:0] S_RST_ON  = 4'd4;
  localparam logic [3:0] S_ISO_ON  = 4'd5;
  localparam logic [3:0] S_PWR_DN  = 4'd6;
  localparam logic [3:0] S_ERR     = 4'd7;
  localparam logic [3:0] S_RET     = 4'd8;

`ifndef EXT_DOMAIN_SEQ_RETENTION_EN
  logic unused_ret;
  assign unused_ret = ^ret_req_i;
`endif

  for (genvar g = 0; g < NDOMAINS; g++) begin : g_dom
    logic [3:0]    state_q, state_d;
    logic [TW-1:0] timer_q;
    logic          pend_q;
    logic          set_pend;

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_OFF:     if (on_req_i[g]) state_d = S_PWR_UP;
        // Ack wins over both abort and timeout in the same cycle.
        S_PWR_UP: begin
          if (switch_ack_i[g])             state_d = S_ISO_OFF;
          else if (!on_req_i[g])           state_d = S_PWR_DN;
          else if (timer_q == ACK_T)       state_d = S_ERR;
        end
        S_ISO_OFF: begin
          if (!on_req_i[g])                state_d = S_ISO_ON;
          else if (timer_q == ISO_T)       state_d = S_RUN;
        end
        S_RUN: begin
          if (!on_req_i[g]) begin
`ifdef EXT_DOMAIN_SEQ_RETENTION_EN
            state_d = ret_req_i[g] ? S_RET : S_RST_ON;
`else
            state_d = S_RST_ON;
`endif
          end
        end
        S_RST_ON:  state_d = S_ISO_ON;
        S_ISO_ON:  state_d = S_PWR_DN;
        S_PWR_DN: begin
          if (!switch_ack_i[g])            state_d = S_OFF;
          else if (timer_q == ACK_T)       state_d = S_ERR;
        end
        S_ERR:     if (err_clr_i[g] && !on_req_i[g]) state_d = S_OFF;
`ifdef EXT_DOMAIN_SEQ_RETENTION_EN
        S_RET: begin
          if (on_req_i[g])                 state_d = S_ISO_OFF;
          else if (!ret_req_i[g])          state_d = S_ISO_ON;
        end
`endif
        default:   state_d = S_OFF;
      endcase
    end

    // Reset-forced OFF does not raise an interrupt; only sequenced entries do.
    assign set_pend = (state_d != state_q) &&
                      ((state_d == S_RUN) || (state_d == S_ERR) ||
                       ((state_d == S_OFF) && (state_q == S_PWR_DN)));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= S_OFF;
        timer_q <= '0;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        if (state_d != state_q)  timer_q <= '0;
        else if (timer_q != T_SAT) timer_q <= timer_q + 1'b1;
        pend_q  <= set_pend | (pend_q & ~intr_clr_i[g]);
      end
    end

    assign switch_o[g] = (state_q == S_PWR_UP) || (state_q == S_ISO_OFF) ||
                         (state_q == S_RUN) || (state_q == S_RST_ON) ||
                         (state_q == S_ISO_ON) || (state_q == S_RET);
    assign iso_o[g]    = (state_q == S_OFF) || (state_q == S_PWR_UP) ||
                         (state_q == S_ISO_ON) || (state_q == S_PWR_DN) ||
                         (state_q == S_ERR) || (state_q == S_RET);
    assign rst_no[g]   = (state_q == S_RUN);
    assign ready_o[g]  = (state_q == S_RUN);
    assign err_o[g]    = (state_q == S_ERR);
`ifdef EXT_DOMAIN_SEQ_RETENTION_EN
    assign set_retentive_o[g] = (state_q == S_RET);
`else
    assign set_retentive_o[g] = 1'b0;
`endif
    assign intr_pending_o[g]        = pend_q;
    assign state_dbg_o[4*g +: 4]    = state_q;
  end

  assign intr_o = |(intr_pending_o & intr_en_i);

endmodule

// File: tb/tb_ext_domain_seq.sv
// Bench for ext_domain_seq: directed sequences plus random traffic, every cycle
// compared against a phase/cycle-count reference model.
module tb_ext_domain_seq;
  localparam int ND     = 2;
  localparam int ACK_TO = 8;
  localparam int RD     = 4;

  logic clk = 1'b0;
  logic rst;
  logic [ND-1:0] on_req, ack, err_clr, intr_en, intr_clr, ret_req;
  logic [ND-1:0] switch_o, iso_o, rst_no, set_ret, ready_o, err_o, pend_o;
  logic          intr_o;
  logic [4*ND-1:0] state_dbg;

  always #5 clk = ~clk;

  ext_domain_seq #(.NDOMAINS(ND), .ACK_TIMEOUT(ACK_TO), .RST_DELAY(RD)) dut (
    .clk_i(clk), .rst_i(rst), .on_req_i(on_req), .switch_ack_i(ack),
    .err_clr_i(err_clr), .intr_en_i(intr_en), .intr_clr_i(intr_clr),
    .ret_req_i(ret_req), .switch_o(switch_o), .iso_o(iso_o), .rst_no(rst_no),
    .set_retentive_o(set_ret), .ready_o(ready_o), .err_o(err_o),
    .intr_pending_o(pend_o), .intr_o(intr_o), .state_dbg_o(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: named phase plus an unbounded count of cycles spent in it.
  typedef enum int {M_OFF, M_PUP, M_ISOOFF, M_RUN, M_RSTON, M_ISOON, M_PDN, M_ERR, M_RET} mphase_t;
  mphase_t ph[ND];
  int      cyc[ND];
  bit      pend[ND];

  function automatic mphase_t next_phase(int d);
    case (ph[d])
      M_OFF:    return on_req[d] ? M_PUP : M_OFF;
      M_PUP: begin
        if (ack[d]) return M_ISOOFF;
        if (!on_req[d]) return M_PDN;
        if (cyc[d] == ACK_TO) return M_ERR;
        return M_PUP;
      end
      M_ISOOFF: begin
        if (!on_req[d]) return M_ISOON;
        if (cyc[d] == RD - 1) return M_RUN;
        return M_ISOOFF;
      end
      M_RUN: begin
        if (on_req[d]) return M_RUN;
`ifdef EXT_DOMAIN_SEQ_RETENTION_EN
        if (ret_req[d]) return M_RET;
`endif
        return M_RSTON;
      end
      M_RSTON:  return M_ISOON;
      M_ISOON:  return M_PDN;
      M_PDN: begin
        if (!ack[d]) return M_OFF;
        if (cyc[d] == ACK_TO) return M_ERR;
        return M_PDN;
      end
      M_ERR:    return (err_clr[d] && !on_req[d]) ? M_OFF : M_ERR;
      M_RET: begin
        if (on_req[d]) return M_ISOOFF;
        if (!ret_req[d]) return M_ISOON;
        return M_RET;
      end
      default:  return M_OFF;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        ph[d] = M_OFF; cyc[d] = 0; pend[d] = 0;
      end else begin
        mphase_t nx;
        bit set;
        nx  = next_phase(d);
        set = 0;
        if (nx != ph[d]) begin
          set = (nx == M_RUN) || (nx == M_ERR) || (nx == M_OFF && ph[d] == M_PDN);
          ph[d] = nx; cyc[d] = 0;
        end else begin
          cyc[d]++;
        end
        pend[d] = set ? 1'b1 : (intr_clr[d] ? 1'b0 : pend[d]);
      end
    end
  end

  // (switch, iso, rst_n, ready, err, retentive) for each phase
  function automatic logic [5:0] phase_out(mphase_t p);
    case (p)
      M_OFF:    return 6'b010000;
      M_PUP:    return 6'b110000;
      M_ISOOFF: return 6'b100000;
      M_RUN:    return 6'b101100;
      M_RSTON:  return 6'b100000;
      M_ISOON:  return 6'b110000;
      M_PDN:    return 6'b010000;
      M_ERR:    return 6'b010010;
      M_RET:    return 6'b110001;
      default:  return 6'b000000;
    endcase
  endfunction

  task automatic compare_all();
    logic [ND-1:0] e_sw, e_iso, e_rn, e_rdy, e_err, e_ret, e_pend;
    for (int d = 0; d < ND; d++) begin
      logic [5:0] o;
      o = phase_out(ph[d]);
      {e_sw[d], e_iso[d], e_rn[d], e_rdy[d], e_err[d], e_ret[d]} = o;
      e_pend[d] = pend[d];
    end
    check("switch_o", 32'(switch_o), 32'(e_sw));
    check("iso_o", 32'(iso_o), 32'(e_iso));
    check("rst_no", 32'(rst_no), 32'(e_rn));
    check("ready_o", 32'(ready_o), 32'(e_rdy));
    check("err_o", 32'(err_o), 32'(e_err));
    check("set_retentive_o", 32'(set_ret), 32'(e_ret));
    check("intr_pending_o", 32'(pend_o), 32'(e_pend));
    check("intr_o", 32'(intr_o), 32'(|(e_pend & intr_en)));
  endtask

  // Switch model: ack replays switch_o with a per-domain latency, or is stuck.
  int          ack_mode[ND];
  int          ack_lat[ND];
  logic [15:0] sw_hist[ND];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    for (int d = 0; d < ND; d++) begin
      sw_hist[d] = {sw_hist[d][14:0], switch_o[d]};
      case (ack_mode[d])
        0:       ack[d] = sw_hist[d][ack_lat[d]-1];
        1:       ack[d] = 1'b0;
        default: ack[d] = 1'b1;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; on_req = '0; ack = '0; err_clr = '0; intr_en = '0;
    intr_clr = '0; ret_req = '0;
    for (int d = 0; d < ND; d++) begin
      ack_mode[d] = 0; ack_lat[d] = 3; sw_hist[d] = '0;
    end
    idle(3);
    check("rst_iso_all_ones", 32'(iso_o), 32'({ND{1'b1}}));
    check("rst_switch_zero", 32'(switch_o), 32'd0);
    rst = 1'b0;
    idle(2);

    // Power-up with ack latency 3; intr_clr held to show set beats clear.
    intr_clr[0] = 1'b1;
    on_req[0]   = 1'b1;
    n = 0;
    do begin step(); n++; end while (!ready_o[0] && n < 50);
    check("pwrup_latency", 32'(n), 32'(1 + 3 + RD));
    check("pend_set_wins", 32'(pend_o[0]), 32'd1);
    check("dom1_idle", 32'({switch_o[1], iso_o[1], rst_no[1], ready_o[1]}), 32'b0100);
    intr_clr[0] = 1'b0;
    check("intr_masked", 32'(intr_o), 32'd0);
    intr_en[0] = 1'b1;
    #1;
    check("intr_unmask_same_cycle", 32'(intr_o), 32'd1);
    intr_clr[0] = 1'b1;
    step();
    intr_clr[0] = 1'b0;
    check("intr_cleared", 32'(pend_o[0]), 32'd0);

    // Ordered power-down: rst_n, then iso, then switch.
    on_req[0] = 1'b0;
    step();
    check("pdn_c1", 32'({switch_o[0], iso_o[0], rst_no[0]}), 32'b100);
    step();
    check("pdn_c2", 32'({switch_o[0], iso_o[0], rst_no[0]}), 32'b110);
    step();
    check("pdn_c3", 32'({switch_o[0], iso_o[0], rst_no[0]}), 32'b010);
    n = 3;
    while (!pend_o[0] && n < 50) begin step(); n++; end
    check("pwrdn_latency", 32'(n), 32'(3 + 3));

    // Acknowledge timeout, then error clear rules.
    intr_clr[0] = 1'b1; step(); intr_clr[0] = 1'b0;
    ack_mode[0] = 1;
    on_req[0]   = 1'b1;
    n = 0;
    do begin step(); n++; end while (!err_o[0] && n < 50);
    check("timeout_latency", 32'(n), 32'(ACK_TO + 2));
    check("timeout_switch_off", 32'(switch_o[0]), 32'd0);
    err_clr[0] = 1'b1; step(); err_clr[0] = 1'b0;
    check("errclr_ignored_on", 32'(err_o[0]), 32'd1);
    on_req[0] = 1'b0;
    err_clr[0] = 1'b1; step(); err_clr[0] = 1'b0;
    check("errclr_honoured", 32'(err_o[0]), 32'd0);
    ack_mode[0] = 0;
    idle(20);

    // Ack arriving exactly at the timeout count.
    ack_lat[0] = ACK_TO + 1;
    on_req[0]  = 1'b1;
    seen = 0; n = 0;
    do begin step(); n++; if (err_o[0]) seen = 1; end while (!ready_o[0] && n < 50);
    check("ack_at_timeout_no_err", 32'(seen), 32'd0);
    check("ack_at_timeout_ready", 32'(ready_o[0]), 32'd1);
    ack_lat[0] = 3;
    on_req[0]  = 1'b0;
    idle(20);

    // Reset in ISO_OFF.
    on_req[0] = 1'b1;
    idle(4);
    check("in_iso_off", 32'({switch_o[0], iso_o[0]}), 32'b10);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_mid_switch", 32'(switch_o), 32'd0);
    check("rst_mid_iso", 32'(iso_o), 32'({ND{1'b1}}));
    n = 0;
    do begin step(); n++; end while (!ready_o[0] && n < 50);
    check("repower_ready", 32'(ready_o[0]), 32'd1);

`ifdef EXT_DOMAIN_SEQ_RETENTION_EN
    ret_req[0] = 1'b1;
    on_req[0]  = 1'b0;
    step();
    check("ret_entered", 32'({switch_o[0], iso_o[0], rst_no[0], set_ret[0]}), 32'b1101);
    on_req[0] = 1'b1;
    seen = 0; n = 0;
    do begin step(); n++; if (!switch_o[0]) seen = 1; end while (!ready_o[0] && n < 50);
    check("ret_resume_ready", 32'(ready_o[0]), 32'd1);
    check("ret_switch_held", 32'(seen), 32'd0);
    check("ret_resume_latency", 32'(n), 32'(1 + RD));
    ret_req[0] = 1'b0;
`endif

    // Random traffic on all domains.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < ND; d++) begin
        if ($urandom_range(0, 19) == 0) begin
          on_req[d]   = ~on_req[d];
          ack_mode[d] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
          ack_lat[d]  = int'($urandom_range(1, 6));
          ret_req[d]  = 1'($urandom_range(0, 1));
        end
        err_clr[d]  = ($urandom_range(0, 5) == 0);
        intr_clr[d] = ($urandom_range(0, 7) == 0);
        intr_en[d]  = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
